// File: rtl/regfile_arb.sv
// Register file shared by two read clients and one writeback client, one access per cycle.
// Writes win by default, a read is forced right after a write, and the two readers alternate.
module regfile_arb #(
    parameter int REG_SZ = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd0_re,
    input  logic [4:0]        rd0_idx,
    output logic              rd0_rack,
    output logic [REG_SZ-1:0] rd0_data,
    input  logic              rd1_re,
    input  logic [4:0]        rd1_idx,
    output logic              rd1_rack,
    output logic [REG_SZ-1:0] rd1_data,
    input  logic              wr_we,
    input  logic [4:0]        wr_idx,
    input  logic [REG_SZ-1:0] wr_data,
    output logic              wr_wack,
    output logic              busy
);
    localparam int NREG = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_RD = 2'd1,
        GNT_WR = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic [REG_SZ-1:0] r_mem [NREG];
    logic              r_rd0_rack;
    logic              r_rd1_rack;
    logic              r_wr_wack;
    logic              r_busy;
    logic [REG_SZ-1:0] r_rd0_data;
    logic [REG_SZ-1:0] r_rd1_data;

    logic              w_rd0_elig;
    logic              w_rd1_elig;
    logic              w_wr_elig;
    logic              w_pick_rd;
    logic              w_rd_sel;
    logic              w_gnt_wr;
    logic [4:0]        w_rd_idx;
    logic [REG_SZ-1:0] w_rd_val;

    // A requester whose ack is showing this cycle is masked so one request is served once.
    assign w_rd0_elig = rd0_re & ~r_rd0_rack;
    assign w_rd1_elig = rd1_re & ~r_rd1_rack;
    assign w_wr_elig  = wr_we & ~r_wr_wack;

    // Grant selection and read-port mux for the access chosen this cycle.
    always_comb begin
        w_pick_rd = 1'b0;
        w_gnt_wr  = 1'b0;
        w_rd_sel  = r_ptr;
        if (w_rd0_elig && w_rd1_elig) begin
            w_rd_sel = r_ptr;
        end else begin
            w_rd_sel = w_rd1_elig;
        end
        if ((w_rd0_elig || w_rd1_elig) && ((r_state == GNT_WR) || !w_wr_elig)) begin
            w_pick_rd = 1'b1;
        end else begin
            w_gnt_wr = w_wr_elig;
        end
        w_rd_idx = w_rd_sel ? rd1_idx : rd0_idx;
        if (w_rd_idx == 5'd0) begin
            w_rd_val = '0;
        end else begin
            w_rd_val = r_mem[w_rd_idx];
        end
    end

    // Grant FSM, register array and registered acknowledges/read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_rd0_rack <= 1'b0;
            r_rd1_rack <= 1'b0;
            r_wr_wack  <= 1'b0;
            r_busy     <= 1'b0;
            r_rd0_data <= '0;
            r_rd1_data <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rd0_rack <= w_pick_rd & ~w_rd_sel;
            r_rd1_rack <= w_pick_rd & w_rd_sel;
            r_wr_wack  <= w_gnt_wr;
            r_busy     <= w_pick_rd | w_gnt_wr;
            if (w_pick_rd) begin
                r_state <= GNT_RD;
                r_ptr   <= ~w_rd_sel;
                if (w_rd_sel) begin
                    r_rd1_data <= w_rd_val;
                end else begin
                    r_rd0_data <= w_rd_val;
                end
            end else if (w_gnt_wr) begin
                r_state <= GNT_WR;
                // Index 0 is hard-wired to zero: the write is acknowledged but dropped.
                if (wr_idx != 5'd0) begin
                    r_mem[wr_idx] <= wr_data;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign rd0_rack = r_rd0_rack;
    assign rd1_rack = r_rd1_rack;
    assign wr_wack  = r_wr_wack;
    assign busy     = r_busy;
    assign rd0_data = r_rd0_data;
    assign rd1_data = r_rd1_data;

endmodule

// File: tb/tb_regfile_arb.sv
// Scoreboard bench for regfile_arb: job-queue driven stimulus, behavioural model, per-cycle monitor.
module tb_regfile_arb;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         rd0_re = 1'b0, rd1_re = 1'b0, wr_we = 1'b0;
    logic [4:0]   rd0_idx = 5'd0, rd1_idx = 5'd0, wr_idx = 5'd0;
    logic [W-1:0] wr_data = '0;
    logic         rd0_rack, rd1_rack, wr_wack, busy;
    logic [W-1:0] rd0_data, rd1_data;

    regfile_arb #(.REG_SZ(W)) dut (
        .clk(clk), .rst(rst),
        .rd0_re(rd0_re), .rd0_idx(rd0_idx), .rd0_rack(rd0_rack), .rd0_data(rd0_data),
        .rd1_re(rd1_re), .rd1_idx(rd1_idx), .rd1_rack(rd1_rack), .rd1_data(rd1_data),
        .wr_we(wr_we), .wr_idx(wr_idx), .wr_data(wr_data), .wr_wack(wr_wack),
        .busy(busy)
    );

    typedef struct { int cyc; int who; logic [W-1:0] data; } exp_t;
    typedef struct { logic [4:0] idx; logic [W-1:0] data; int life; } job_t;

    exp_t exp_q[$];
    job_t jq[3][$];          // 0: reader 0, 1: reader 1, 2: writer
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    logic [W-1:0] m_mem [32];
    bit   [2:0]   m_ack;
    bit           m_last_wr;
    int           m_ptr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_ack     = 3'b000;
        m_last_wr = 1'b0;
        m_ptr     = 0;
    endtask

    // Predict what the coming rising edge does with the inputs now being presented.
    task automatic model_step();
        bit   [2:0] e;
        int         g;
        logic [4:0] ridx;
        exp_t       x;
        if (rst) begin
            model_reset();
            return;
        end
        e[0] = rd0_re && !m_ack[0];
        e[1] = rd1_re && !m_ack[1];
        e[2] = wr_we  && !m_ack[2];
        g = -1;
        if ((e[0] || e[1]) && (m_last_wr || !e[2])) g = (e[0] && e[1]) ? m_ptr : (e[0] ? 0 : 1);
        else if (e[2]) g = 2;
        m_ack     = 3'b000;
        m_last_wr = (g == 2);
        x.cyc = cyc + 1;
        x.who = g;
        x.data = '0;
        if (g == 2) begin
            if (wr_idx != 5'd0) m_mem[wr_idx] = wr_data;
            exp_q.push_back(x);
            m_ack[2] = 1'b1;
        end else if (g >= 0) begin
            ridx = (g == 1) ? rd1_idx : rd0_idx;
            x.data = (ridx == 5'd0) ? '0 : m_mem[ridx];
            exp_q.push_back(x);
            m_ack[g] = 1'b1;
            m_ptr = 1 - g;
        end
    endtask

    // One cycle of the client agents: retire served/abandoned jobs, present the next ones.
    task automatic tick(input bit rst_v);
        bit [2:0] ack_s, req_s, gap;
        job_t     j;
        @(negedge clk);
        ack_s = {wr_wack, rd1_rack, rd0_rack};
        req_s = {wr_we, rd1_re, rd0_re};
        gap   = 3'b000;
        for (int r = 0; r < 3; r++) begin
            if (req_s[r] && jq[r].size() > 0) begin
                j = jq[r].pop_front();
                if (ack_s[r]) begin
                end else if (j.life == 1) begin
                    gap[r] = 1'b1;
                end else begin
                    if (j.life > 1) j.life--;
                    jq[r].push_front(j);
                end
            end
        end
        rst = rst_v;
        rd0_re = !gap[0] && jq[0].size() > 0;
        if (rd0_re) begin j = jq[0][0]; rd0_idx = j.idx; end
        rd1_re = !gap[1] && jq[1].size() > 0;
        if (rd1_re) begin j = jq[1][0]; rd1_idx = j.idx; end
        wr_we = !gap[2] && jq[2].size() > 0;
        if (wr_we) begin j = jq[2][0]; wr_idx = j.idx; wr_data = j.data; end
        model_step();
    endtask

    task automatic push_job(input int r, input logic [4:0] idx, input logic [W-1:0] data, input int life);
        job_t j;
        j.idx = idx; j.data = data; j.life = life;
        jq[r].push_back(j);
    endtask

    task automatic drain(input string name);
        int left;
        int budget = 0;
        while ((jq[0].size() + jq[1].size() + jq[2].size()) > 0 && budget < 100) begin
            tick(1'b0);
            budget++;
        end
        left = jq[0].size() + jq[1].size() + jq[2].size();
        chk(name, W'(left), '0);
        tick(1'b0);
    endtask

    // Monitor: pop the expectation for this cycle and compare every output.
    initial begin
        bit   [2:0]   exp_v;
        logic [W-1:0] hold0 = '0;
        logic [W-1:0] hold1 = '0;
        exp_t         x;
        forever begin
            @(posedge clk);
            #1;
            exp_v = 3'b000;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                x = exp_q.pop_front();
                exp_v[x.who] = 1'b1;
                if (x.who == 0) hold0 = x.data;
                if (x.who == 1) hold1 = x.data;
            end
            if (rst) begin
                hold0 = '0;
                hold1 = '0;
            end
            chk("ack_vector", W'({wr_wack, rd1_rack, rd0_rack}), W'(exp_v));
            chk("busy", W'(busy), W'(|exp_v));
            chk("rd0_data", rd0_data, hold0);
            chk("rd1_data", rd1_data, hold1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick(1'b1);
        tick(1'b0);

        // Write then read back through reader 0.
        push_job(2, 5'd5, 32'hDEADBEEF, 0);
        tick(1'b0);
        push_job(0, 5'd5, '0, 0);
        drain("drain_wr_rd");

        // Index 0 write is discarded.
        push_job(2, 5'd0, 32'h00001234, 0);
        tick(1'b0);
        push_job(1, 5'd0, '0, 0);
        drain("drain_idx0");

        // Both readers together after reset, preloaded values.
        tick(1'b1);
        push_job(2, 5'd3, 32'h00000033, 0);
        push_job(2, 5'd4, 32'h00000044, 0);
        drain("drain_preload");
        push_job(0, 5'd3, '0, 0);
        push_job(1, 5'd4, '0, 0);
        drain("drain_two_readers");

        // Continuous writes competing with a reader.
        for (int k = 0; k < 4; k++) push_job(2, 5'd7, 32'hA0A0_0000 + W'(k), 0);
        push_job(0, 5'd7, '0, 0);
        drain("drain_wr_stream");

        // Reset with a read presented, and reset right after a read ack.
        push_job(2, 5'd9, 32'h99999999, 0);
        drain("drain_idx9");
        push_job(0, 5'd9, '0, 0);
        tick(1'b1);
        drain("drain_rd_after_rst");
        push_job(2, 5'd9, 32'h12345678, 0);
        drain("drain_idx9_again");
        push_job(1, 5'd9, '0, 0);
        tick(1'b0);
        tick(1'b1);
        drain("drain_rst_after_ack");

        // Reader 0 pulses for one cycle while the write wins.
        push_job(2, 5'd12, 32'hC0C0C0C0, 0);
        push_job(0, 5'd12, '0, 1);
        drain("drain_pulse");
        push_job(0, 5'd12, '0, 0);
        drain("drain_pulse_readback");

        // Randomised traffic with abandonment and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            for (int r = 0; r < 3; r++) begin
                if (jq[r].size() < 2 && $urandom_range(99) < 35) begin
                    push_job(r,
                             ($urandom_range(1) == 1) ? 5'($urandom_range(7)) : 5'($urandom_range(31)),
                             W'($urandom),
                             ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0);
                end
            end
            tick($urandom_range(199) == 0);
        end
        drain("drain_random");
        tick(1'b0);
        chk("exp_queue_empty", W'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
